// File: rtl/edge_event_fifo_if.sv
// Edge-event FIFO bus: producer-side anyedge/clr_ovf, consumer-side valid/ready read port.
// Optional EDGE_DROP_CNT_EN adds the drop_cnt status signal.
interface edge_event_fifo_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 16
);
    logic [WIDTH-1:0]         anyedge;
    logic                     rd_ready;
    logic                     clr_ovf;
    logic                     rd_valid;
    logic [WIDTH-1:0]         rd_data;
    logic [TS_W-1:0]          rd_ts;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
`ifdef EDGE_DROP_CNT_EN
    logic [7:0]               drop_cnt;
`endif

    // Environment side: drives events and the read handshake, observes status.
    modport master (
        output anyedge,
        output rd_ready,
        output clr_ovf,
        input  rd_valid,
        input  rd_data,
        input  rd_ts,
        input  count,
`ifdef EDGE_DROP_CNT_EN
        input  drop_cnt,
`endif
        input  overflow
    );

    // FIFO side.
    modport slave (
        input  anyedge,
        input  rd_ready,
        input  clr_ovf,
        output rd_valid,
        output rd_data,
        output rd_ts,
        output count,
`ifdef EDGE_DROP_CNT_EN
        output drop_cnt,
`endif
        output overflow
    );
endinterface

// File: rtl/edge_event_fifo.sv
// Timestamped first-word-fall-through FIFO of non-zero edge-event vectors.
// Optional macro EDGE_DROP_CNT_EN adds a saturating 8-bit dropped-event counter.
module edge_event_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    edge_event_fifo_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [TS_W-1:0]  r_ts;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic [WIDTH-1:0] r_mem_data [DEPTH];
    logic [TS_W-1:0]  r_mem_ts   [DEPTH];

    logic w_push_req;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Handshake decode; full/empty come from the occupancy count only.
    always_comb begin
        w_push_req = |bus.anyedge;
        w_empty    = (r_count == '0);
        w_full     = (r_count == CNT_W'(DEPTH));
        w_pop      = !w_empty && bus.rd_ready;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        w_push     = w_push_req && (!w_full || w_pop);
        w_drop     = w_push_req && w_full && !w_pop;
    end

    // FWFT head presentation, zeroed when nothing is stored.
    always_comb begin
        bus.rd_valid = !w_empty;
        bus.rd_data  = '0;
        bus.rd_ts    = '0;
        if (!w_empty) begin
            bus.rd_data = r_mem_data[r_rd_ptr];
            bus.rd_ts   = r_mem_ts[r_rd_ptr];
        end
        bus.count    = r_count;
        bus.overflow = r_overflow;
    end

    // Free-running timestamp, wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_data[r_wr_ptr] <= bus.anyedge;
            r_mem_ts[r_wr_ptr]   <= r_ts;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; a drop wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef EDGE_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating drop counter; clear with a same-cycle drop leaves one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (bus.clr_ovf) begin
            r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    // Export the counter.
    always_comb begin
        bus.drop_cnt = r_drop_cnt;
    end
`endif

endmodule

// File: tb/tb_edge_event_fifo.sv
// Directed bench for edge_event_fifo with a queue scoreboard checked every cycle.
// Also covers EDGE_DROP_CNT_EN when that macro is defined.
module tb_edge_event_fifo;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TS_W  = 16;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [TS_W-1:0]  t;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    edge_event_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W)) bus ();
    edge_event_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(4))    bus4 ();

    edge_event_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    edge_event_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    ent_t            sb[$];
    logic [TS_W-1:0] m_ts;
    logic            m_ovf;
    int              m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the scoreboard head and model state.
    task automatic check_outputs();
        logic [WIDTH-1:0] ed;
        logic [TS_W-1:0]  et;
        ed = '0;
        et = '0;
        if (sb.size() != 0) begin
            ed = sb[0].d;
            et = sb[0].t;
        end
        chk("rd_valid", 32'(bus.rd_valid), 32'(sb.size() != 0));
        chk("rd_data", 32'(bus.rd_data), 32'(ed));
        chk("rd_ts", 32'(bus.rd_ts), 32'(et));
        chk("count", 32'(bus.count), 32'(sb.size()));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
`ifdef EDGE_DROP_CNT_EN
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
`endif
    endtask

    // One clock cycle: drive, check current state, clock, update model.
    task automatic step(input logic [WIDTH-1:0] ae, input logic rdy, input logic clr);
        logic pop;
        logic full;
        logic drop;
        bus.anyedge  = ae;
        bus.rd_ready = rdy;
        bus.clr_ovf  = clr;
        check_outputs();
        @(posedge clk);
        #1;
        pop  = (sb.size() != 0) && rdy;
        full = (sb.size() == DEPTH);
        drop = 1'b0;
        if (pop) begin
            void'(sb.pop_front());
        end
        if (ae != '0) begin
            if (!full || pop) begin
                sb.push_back('{d: ae, t: m_ts});
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) begin
            m_ovf = 1'b1;
        end else if (clr) begin
            m_ovf = 1'b0;
        end
        if (clr) begin
            m_drop = drop ? 1 : 0;
        end else if (drop && m_drop < 255) begin
            m_drop++;
        end
        m_ts = m_ts + 1'b1;
    endtask

    // One reset cycle with the given anyedge sample, which must not be stored.
    task automatic reset_step(input logic [WIDTH-1:0] ae);
        rst          = 1'b1;
        bus.anyedge  = ae;
        bus.rd_ready = 1'b0;
        bus.clr_ovf  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_ts   = '0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    initial begin
        bus.anyedge   = '0;
        bus.rd_ready  = 1'b0;
        bus.clr_ovf   = 1'b0;
        bus4.anyedge  = '0;
        bus4.rd_ready = 1'b0;
        bus4.clr_ovf  = 1'b0;

        // Idle after reset.
        reset_step('0);
        for (int i = 0; i < 20; i++) step('0, 1'b0, 1'b0);
        chk("idle_valid", 32'(bus.rd_valid), 32'd0);
        chk("idle_count", 32'(bus.count), 32'd0);
        chk("idle_data", 32'(bus.rd_data), 32'd0);
        chk("idle_ovf", 32'(bus.overflow), 32'd0);

        // Single event latency and timestamp.
        reset_step('0);
        for (int i = 0; i < 3; i++) step('0, 1'b1, 1'b0);
        step(8'h05, 1'b1, 1'b0);
        chk("lat_valid", 32'(bus.rd_valid), 32'd1);
        chk("lat_data", 32'(bus.rd_data), 32'h05);
        chk("lat_ts", 32'(bus.rd_ts), 32'd3);
        step('0, 1'b1, 1'b0);
        chk("lat_empty_valid", 32'(bus.rd_valid), 32'd0);
        chk("lat_empty_count", 32'(bus.count), 32'd0);

        // Overfill by one with reads stalled.
        reset_step('0);
        for (int i = 1; i <= 9; i++) step(WIDTH'(i), 1'b0, 1'b0);
        chk("full_count", 32'(bus.count), 32'd8);
        chk("full_ovf", 32'(bus.overflow), 32'd1);
`ifdef EDGE_DROP_CNT_EN
        chk("full_drop_cnt", 32'(bus.drop_cnt), 32'd1);
`endif
        // Held outputs while stalled.
        step('0, 1'b0, 1'b0);
        chk("stall_data", 32'(bus.rd_data), 32'h01);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", 32'(bus.rd_data), 32'(i));
            chk("drain_ts", 32'(bus.rd_ts), 32'(i - 1));
            step('0, 1'b1, 1'b0);
        end
        chk("drained_valid", 32'(bus.rd_valid), 32'd0);
        step('0, 1'b1, 1'b1);
        chk("clr_ovf", 32'(bus.overflow), 32'd0);

        // Full FIFO with simultaneous push and pop; then drop racing clear.
        reset_step('0);
        for (int i = 1; i <= 8; i++) step(WIDTH'(8'h30 + i), 1'b0, 1'b0);
        step(8'hFF, 1'b1, 1'b0);
        chk("pp_count", 32'(bus.count), 32'd8);
        chk("pp_ovf", 32'(bus.overflow), 32'd0);
        step(8'h77, 1'b0, 1'b1);
        chk("race_ovf", 32'(bus.overflow), 32'd1);
`ifdef EDGE_DROP_CNT_EN
        chk("race_drop_cnt", 32'(bus.drop_cnt), 32'd1);
`endif
        for (int i = 0; i < 7; i++) step('0, 1'b1, 1'b0);
        chk("pp_last", 32'(bus.rd_data), 32'hFF);
        step('0, 1'b1, 1'b0);
        chk("pp_empty", 32'(bus.rd_valid), 32'd0);

        // Narrow timestamp wrap on the TS_W=4 instance.
        reset_step('0);
        for (int i = 0; i < 15; i++) step('0, 1'b0, 1'b0);
        bus4.anyedge = 8'hA1;
        step('0, 1'b0, 1'b0);
        bus4.anyedge = 8'hB2;
        step('0, 1'b0, 1'b0);
        bus4.anyedge = '0;
        chk("wrap_count", 32'(bus4.count), 32'd2);
        chk("wrap_data0", 32'(bus4.rd_data), 32'hA1);
        chk("wrap_ts0", 32'(bus4.rd_ts), 32'd15);
        bus4.rd_ready = 1'b1;
        step('0, 1'b0, 1'b0);
        chk("wrap_data1", 32'(bus4.rd_data), 32'hB2);
        chk("wrap_ts1", 32'(bus4.rd_ts), 32'd0);
        step('0, 1'b0, 1'b0);
        chk("wrap_empty", 32'(bus4.rd_valid), 32'd0);
        bus4.rd_ready = 1'b0;

        // Reset mid-stream discards contents and the reset-cycle sample.
        for (int i = 0; i < DEPTH; i++) step(8'h44, 1'b0, 1'b0);
        step(8'h45, 1'b0, 1'b0);
        chk("pre_rst_ovf", 32'(bus.overflow), 32'd1);
        reset_step('0);
        for (int i = 1; i <= 3; i++) step(WIDTH'(8'h50 + i), 1'b0, 1'b0);
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        reset_step(8'h10);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_data", 32'(bus.rd_data), 32'd0);
        step(8'h20, 1'b0, 1'b0);
        chk("rst_ts_restart", 32'(bus.rd_ts), 32'd0);
        chk("rst_new_data", 32'(bus.rd_data), 32'h20);
        step('0, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/edge_event_fifo.md
Name: edge_event_fifo

Overview:
Downstream consumer of detect_both_edge. Samples the registered `anyedge` vector every cycle. Each non-zero vector is stored, together with a free-running timestamp, into a small first-word-fall-through FIFO. A valid/ready read port lets software-facing or arbitration logic drain edge events without losing ordering.

Parameters:
WIDTH, 8, width of the anyedge vector and of stored event data
DEPTH, 8, FIFO entries; power of two, >= 2
TS_W, 16, timestamp counter width

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous, active-high reset
anyedge  input  WIDTH  edge-event vector from detect_both_edge; bit=1 means an edge on that lane
rd_ready  input  1  consumer accepts the head entry this cycle
clr_ovf  input  1  clears the sticky overflow flag
rd_valid  output  1  FIFO non-empty; head entry presented
rd_data  output  WIDTH  head entry event vector
rd_ts  output  TS_W  head entry timestamp
count  output  $clog2(DEPTH)+1  current number of stored entries
overflow  output  1  sticky flag: at least one event dropped

Behaviour:
- Reset (rst=1 at posedge):
  - ts counter = 0, write/read pointers = 0, count = 0.
  - overflow = 0, rd_valid = 0, rd_data = 0, rd_ts = 0.
  - Reset mid-operation discards all stored entries. Memory contents need not be cleared.
- Timestamp:
  - ts increments by 1 every non-reset cycle.
  - Wraps from 2^TS_W-1 to 0 with no flag.
- Push condition:
  - push_req = |anyedge.
  - Stored entry = {anyedge, ts}, where ts is the counter value in the same cycle anyedge is sampled.
- Pop condition: pop = rd_valid && rd_ready.
- Full (count == DEPTH) with push_req:
  - If pop is also asserted in that cycle, the push is accepted (pop frees the slot in the same cycle).
  - Otherwise the event is dropped and overflow is set to 1 at the next edge.
- Empty with push_req and rd_ready: no bypass. The entry appears on rd_valid the next cycle.
- Latency: anyedge non-zero in cycle N -> rd_valid=1 with that entry in cycle N+1, if the FIFO was empty.
- FWFT outputs:
  - rd_data/rd_ts show mem[rd_ptr] whenever rd_valid=1.
  - Both are forced to 0 when rd_valid=0.
  - Outputs hold stable while rd_valid=1 and rd_ready=0.
- Count update: count += push_accepted - pop. Simultaneous push and pop leaves count unchanged.
- Pointers:
  - $clog2(DEPTH) bits, wrap modulo DEPTH.
  - Full/empty are derived from count, not from pointer comparison.
- rd_ready while rd_valid=0 is ignored; no pointer movement.
- overflow:
  - Set by a drop; cleared by clr_ovf.
  - Drop and clr_ovf in the same cycle -> overflow=1 (set wins).
- Ordering: strict FIFO. Entries are never merged or reordered.

Optional Feature:
Macro EDGE_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt [7:0], reset to 0.
  - Increments by 1 on each dropped event and saturates at 255.
  - clr_ovf also clears drop_cnt. A same-cycle drop and clr_ovf gives drop_cnt = 1.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then anyedge=0x00 for 20 cycles -> rd_valid=0, count=0, rd_data=0, overflow=0.
- Reset release at ts=0; anyedge=0x05 in cycle 3 only, rd_ready=1 -> in cycle 4: rd_valid=1, rd_data=0x05, rd_ts=3. In cycle 5: rd_valid=0, count=0.
- rd_ready=0; anyedge=0x01,0x02,...,0x09 on 9 consecutive cycles, DEPTH=8:
  - count=8 and overflow=1.
  - Draining yields 0x01..0x08 in order with consecutive timestamps; 0x09 is lost.
  - With EDGE_DROP_CNT_EN: drop_cnt=1.
- FIFO full, then anyedge=0xFF together with rd_ready=1 in the same cycle -> push accepted, count stays 8, overflow unchanged, 0xFF is the last entry drained.
- TS_W=4: event at ts=15 and next event at ts=0 -> rd_ts values 15 then 0, order preserved.
- 3 entries stored, rst=1 for one cycle mid-stream with anyedge=0x10 -> next cycle: count=0, rd_valid=0, overflow=0, ts restarts at 0, and the 0x10 sample is not stored.
